// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------+
// | alu_pkg : shared ALU control encodings, op fields and sequencer FSM  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ALU_1bit.sv
// +----------------------------------------------------------------------+
// | ALU_1bit : one-bit ALU slice (AND/OR/ADD/LESS with operand inverts)  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module ALU_1bit
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       ainvert_i,
    input  logic       binvert_i,
    input  logic       carry_i,
    input  logic       less_i,
    input  logic [1:0] op_i,
    output logic       result_o,
    output logic       carry_o
);

    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff   = a_i ^ ainvert_i;
    assign b_eff   = b_i ^ binvert_i;
    assign sum     = a_eff ^ b_eff ^ carry_i;
    assign carry_o = (a_eff & b_eff) | (a_eff & carry_i) | (b_eff & carry_i);

    always_comb begin
        result_o = 1'b0;
        case (op_i)
            OP_AND:  result_o = a_eff & b_eff;
            OP_OR:   result_o = a_eff | b_eff;
            OP_ADD:  result_o = sum;
            OP_LESS: result_o = less_i;
            default: result_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
// +----------------------------------------------------------------------+
// | alu_serial_ctrl : bit-serial ALU sequencer around one ALU_1bit slice |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       ctrl_in,
    output logic             ready_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic             zero_out,
    output logic             carry_out,
    output logic             overflow_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       ctrl_q;
    logic [CNT_W-1:0] idx_q;
    logic             carry_q;
    logic             ready_q;
    logic             done_q;
    logic             zero_q;
    logic             cout_q;
    logic             ovf_q;

    logic             slice_res;
    logic             slice_cout;
    logic [1:0]       slice_op;
    logic             arith;
    logic             ovf_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] final_d;

    // SLT runs the subtract path; the set bit is formed only at the MSB.
    assign slice_op = (ctrl_q[1:0] == OP_LESS) ? OP_ADD : ctrl_q[1:0];
    assign arith    = ctrl_q[1];
    assign ovf_d    = arith & (carry_q ^ slice_cout);
    assign result_d = {slice_res, result_q[WIDTH-1:1]};
    assign final_d  = (ctrl_q[1:0] == OP_LESS)
                    ? {{(WIDTH-1){1'b0}}, slice_res ^ ovf_d}
                    : result_d;

    ALU_1bit u_slice (
        .a_i       (a_sh_q[0]),
        .b_i       (b_sh_q[0]),
        .ainvert_i (ctrl_q[3]),
        .binvert_i (ctrl_q[2]),
        .carry_i   (carry_q),
        .less_i    (1'b0),
        .op_i      (slice_op),
        .result_o  (slice_res),
        .carry_o   (slice_cout)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            result_q <= '0;
            ctrl_q   <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_in && ready_q) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in;
                        ctrl_q  <= ctrl_in;
                        idx_q   <= '0;
                        carry_q <= ctrl_in[2];
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= slice_cout;
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        result_q <= final_d;
                        zero_q   <= (final_d == '0);
                        cout_q   <= arith & slice_cout;
                        ovf_q    <= ovf_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_out    = ready_q;
    assign done_out     = done_q;
    assign result_out   = result_q;
    assign zero_out     = zero_q;
    assign carry_out    = cout_q;
    assign overflow_out = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_alu_serial_ctrl : randomized bench with arithmetic reference model|
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ctrl;
    logic         ready;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] got_res;
    logic         got_zero;
    logic         got_carry;
    logic         got_ovf;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .start_in     (start),
        .a_in         (a),
        .b_in         (b),
        .ctrl_in      (ctrl),
        .ready_out    (ready),
        .done_out     (done),
        .result_out   (result),
        .zero_out     (zero),
        .carry_out    (carry),
        .overflow_out (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, carry, zero, result} from two's-complement arithmetic.
    function automatic logic [W+2:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic [3:0] c);
        logic [W-1:0] xx, yy, r;
        int           sx, sy, ss;
        logic [W:0]   s;
        logic         cy, ov;
        xx = c[3] ? ~x : x;
        yy = c[2] ? ~y : y;
        s  = {1'b0, xx} + {1'b0, yy} + {{W{1'b0}}, c[2]};
        sx = $signed(xx);
        sy = $signed(yy);
        ss = sx + sy + int'(c[2]);
        cy = 1'b0;
        ov = 1'b0;
        r  = '0;
        case (c[1:0])
            2'b00: r = xx & yy;
            2'b01: r = xx | yy;
            default: begin
                cy = s[W];
                ov = (ss > 127) || (ss < -128);
                if (c[1:0] == 2'b11) r = {{(W-1){1'b0}}, (ss < 0)};
                else                 r = s[W-1:0];
            end
        endcase
        return {ov, cy, (r == '0), r};
    endfunction

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] c);
        logic [W+2:0] exp;
        int           n;
        exp = ref_model(x, y, c);
        @(negedge clk);
        check("ready_before_start", ready, 1);
        a = x; b = y; ctrl = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); ctrl = 4'($urandom);
        check("ready_in_run", ready, 0);
        n = 1;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        check("done_latency", n, W + 1);
        got_res = result; got_zero = zero; got_carry = carry; got_ovf = ovf;
        check("result", result, exp[W-1:0]);
        check("zero", zero, exp[W]);
        check("carry", carry, exp[W+1]);
        check("overflow", ovf, exp[W+2]);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_after_done", ready, 1);
        check("result_held", result, exp[W-1:0]);
    endtask

    initial begin
        int dones;
        int last_done;
        int spacing_bad;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ctrl = '0;
        #12;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {zero, carry, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h7F, 8'h01, 4'b0010);
        check("add7f_res", got_res, 8'h80);
        check("add7f_flags", {got_ovf, got_carry, got_zero}, 3'b100);
        run_op(8'h05, 8'h05, 4'b0110);
        check("sub_eq_flags", {got_ovf, got_carry, got_zero}, 3'b011);
        run_op(8'h00, 8'h01, 4'b0110);
        check("sub_neg_res", got_res, 8'hFF);
        check("sub_neg_carry", got_carry, 0);
        run_op(8'h80, 8'h01, 4'b0111);
        check("slt_lt", got_res, 8'h01);
        run_op(8'h01, 8'h80, 4'b0111);
        check("slt_ge", {got_zero, got_res}, 9'h100);
        run_op(8'h7F, 8'h80, 4'b0111);
        check("slt_ovf", got_res, 8'h00);
        run_op(8'hF0, 8'h0F, 4'b1100);
        check("nor", {got_ovf, got_carry, got_zero, got_res}, 11'h100);
        run_op(8'hF0, 8'h3C, 4'b0000);
        check("and", got_res, 8'h30);
        run_op(8'hF0, 8'h3C, 4'b0001);
        check("or", got_res, 8'hFC);

        for (int i = 0; i < 40; i++)
            run_op(W'($urandom), W'($urandom), 4'($urandom));

        // start pulsed mid-run with other operands must be ignored
        @(negedge clk);
        a = 8'h11; b = 8'h22; ctrl = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk);
        a = 8'h55; b = 8'h01; ctrl = 4'b0110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            if (done) begin
                dones++;
                check("ignored_start_res", result, 8'h33);
            end
            @(negedge clk);
        end
        check("ignored_start_dones", dones, 1);

        // start held high: accepts every W+2 cycles
        a = 8'h10; b = 8'h20; ctrl = 4'b0010; start = 1'b1;
        dones = 0; last_done = -1; spacing_bad = 0;
        for (int i = 0; i < 4 * (W + 2) + 2; i++) begin
            @(negedge clk);
            if (done) begin
                if (last_done >= 0 && (i - last_done) != W + 2) spacing_bad++;
                last_done = i;
                dones++;
                check("b2b_res", result, 8'h30);
            end
        end
        start = 1'b0;
        check("b2b_spacing", spacing_bad, 0);
        check("b2b_count", dones, 4);
        repeat (W + 3) @(negedge clk);

        // reset during bit 3 of a run
        a = 8'hFF; b = 8'hFF; ctrl = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_flags", {zero, carry, ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 2 * (W + 2); i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        run_op(8'h03, 8'h04, 4'b0010);
        check("post_rst_add", got_res, 8'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
